// File: rtl/fft_consts.sv
// Shared FFT datapath constants, the complex sample type and the DW saturation helper.
package fft_consts;

    localparam int DW        = 16;
    localparam int FRAC_BITS = 15;

    typedef struct packed {
        logic signed [DW-1:0] r;
        logic signed [DW-1:0] i;
    } complex_t;

    localparam logic signed [2*DW:0] SAT_MAX = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [2*DW:0] SAT_MIN = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [2*DW:0] RND_HALF =
        {{(2*DW+1-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

    // Clamp any value up to 2*DW+1 bits wide into the signed DW range.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [2*DW:0] x);
        if (x > SAT_MAX) begin
            return SAT_MAX[DW-1:0];
        end else if (x < SAT_MIN) begin
            return SAT_MIN[DW-1:0];
        end
        return x[DW-1:0];
    endfunction

endpackage

// File: rtl/bfu_if.sv
// Butterfly data bundle: the three complex operands in, the two complex results out.
interface bfu_if;
    import fft_consts::*;

    complex_t A_in;
    complex_t B_in;
    complex_t W_in;
    complex_t A_out;
    complex_t B_out;

    modport master (output A_in, output B_in, output W_in, input A_out, input B_out);
    modport slave  (input A_in, input B_in, input W_in, output A_out, output B_out);
endinterface

// File: rtl/bfu_cmul.sv
// Pipelined complex multiply T = B*W: operand register, product register, then
// combinational round-half-up and saturation feeding the butterfly output stage.
module bfu_cmul
    import fft_consts::*;
(
    input  logic     clk,
    input  logic     rst,
    input  complex_t b_i,
    input  complex_t w_i,
    output complex_t t_o
);
    complex_t b_q;
    complex_t w_q;
    logic signed [2*DW-1:0] rr_q, ii_q, ri_q, ir_q;
    logic signed [2*DW:0]   tr_full, ti_full, tr_sh, ti_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q  <= '0;
            w_q  <= '0;
            rr_q <= '0;
            ii_q <= '0;
            ri_q <= '0;
            ir_q <= '0;
        end else begin
            b_q  <= b_i;
            w_q  <= w_i;
            rr_q <= (2*DW)'(b_q.r) * (2*DW)'(w_q.r);
            ii_q <= (2*DW)'(b_q.i) * (2*DW)'(w_q.i);
            ri_q <= (2*DW)'(b_q.r) * (2*DW)'(w_q.i);
            ir_q <= (2*DW)'(b_q.i) * (2*DW)'(w_q.r);
        end
    end

    // One guard bit keeps (-1)*(-1) - (-1)*(+1) exact before rounding.
    always_comb begin
        tr_full = (2*DW+1)'(rr_q) - (2*DW+1)'(ii_q);
        ti_full = (2*DW+1)'(ri_q) + (2*DW+1)'(ir_q);
        tr_sh   = (tr_full + RND_HALF) >>> FRAC_BITS;
        ti_sh   = (ti_full + RND_HALF) >>> FRAC_BITS;
        t_o.r   = sat_dw(tr_sh);
        t_o.i   = sat_dw(ti_sh);
    end

endmodule

// File: rtl/bfu.sv
// Radix-2 DIT butterfly, 3-cycle latency, one result per clock.
// Define BFU_SCALE_EN to halve both outputs (per-stage 1/2 scaling).
module bfu
    import fft_consts::*;
(
    input  logic clk,
    input  logic rst,
    bfu_if.slave bus
);
    complex_t a1_q, a2_q;
    complex_t a_out_q, b_out_q;
    complex_t a_out_d, b_out_d;
    complex_t t;
    logic signed [DW:0] sum_r, sum_i, dif_r, dif_i;

    localparam logic signed [DW:0] ONE = {{DW{1'b0}}, 1'b1};

    function automatic logic signed [DW-1:0] finish_sum(input logic signed [DW:0] s);
        logic signed [2*DW:0] x;
`ifdef BFU_SCALE_EN
        x = (2*DW+1)'((s + ONE) >>> 1);
`else
        x = (2*DW+1)'(s);
`endif
        return sat_dw(x);
    endfunction

    bfu_cmul u_cmul (
        .clk (clk),
        .rst (rst),
        .b_i (bus.B_in),
        .w_i (bus.W_in),
        .t_o (t)
    );

    always_comb begin
        sum_r     = (DW+1)'(a2_q.r) + (DW+1)'(t.r);
        sum_i     = (DW+1)'(a2_q.i) + (DW+1)'(t.i);
        dif_r     = (DW+1)'(a2_q.r) - (DW+1)'(t.r);
        dif_i     = (DW+1)'(a2_q.i) - (DW+1)'(t.i);
        a_out_d.r = finish_sum(sum_r);
        a_out_d.i = finish_sum(sum_i);
        b_out_d.r = finish_sum(dif_r);
        b_out_d.i = finish_sum(dif_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a1_q    <= '0;
            a2_q    <= '0;
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            a1_q    <= bus.A_in;
            a2_q    <= a1_q;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
        end
    end

    assign bus.A_out = a_out_q;
    assign bus.B_out = b_out_q;

endmodule

// File: tb/tb_bfu.sv
// Directed vector bench for bfu: held vectors, back-to-back streaming, mid-stream reset.
module tb_bfu;
    import fft_consts::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    bfu_if bus ();

    bfu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        complex_t a, b, w;
        complex_t ea, eb;   // unscaled expectations
        complex_t sa, sb;   // expectations with 1/2 scaling
    } vec_t;

    localparam int NV = 8;
    vec_t v [NV];

    function automatic complex_t cx(input int r, input int i);
        complex_t c;
        c.r = 16'(r);
        c.i = 16'(i);
        return c;
    endfunction

    function automatic complex_t exp_a(input int k);
`ifdef BFU_SCALE_EN
        return v[k].sa;
`else
        return v[k].ea;
`endif
    endfunction

    function automatic complex_t exp_b(input int k);
`ifdef BFU_SCALE_EN
        return v[k].sb;
`else
        return v[k].eb;
`endif
    endfunction

    task automatic chk(input string nm, input complex_t got, input complex_t req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got (%0d,%0d) required (%0d,%0d)", nm, got.r, got.i, req.r, req.i);
        end
    endtask

    task automatic drive(input complex_t a, input complex_t b, input complex_t w);
        bus.A_in = a;
        bus.B_in = b;
        bus.W_in = w;
    endtask

    initial begin
        //           A                   B                      W                     A_out                B_out                 A_out scaled         B_out scaled
        v[0] = '{cx(8192, 0),      cx(8192, 0),         cx(8192, 0),          cx(10240, 0),       cx(6144, 0),          cx(5120, 0),         cx(3072, 0)};
        v[1] = '{cx(0, 0),         cx(16384, 0),        cx(0, 32767),         cx(0, 16384),       cx(0, -16384),        cx(0, 8192),         cx(0, -8192)};
        v[2] = '{cx(32767, 0),     cx(32767, 0),        cx(32767, 0),         cx(32767, 0),       cx(1, 0),             cx(32767, 0),        cx(1, 0)};
        v[3] = '{cx(-32768, 0),    cx(32767, 0),        cx(32767, 0),         cx(-2, 0),          cx(-32768, 0),        cx(-1, 0),           cx(-32767, 0)};
        v[4] = '{cx(0, 0),         cx(-32768, -32768),  cx(-32768, 32767),    cx(32767, 1),       cx(-32767, -1),       cx(16384, 1),        cx(-16383, 0)};
        v[5] = '{cx(100, -200),    cx(1, -1),           cx(16384, 16384),     cx(101, -200),      cx(99, -200),         cx(51, -100),        cx(50, -100)};
        v[6] = '{cx(0, 0),         cx(-1, 3),           cx(16384, 0),         cx(0, 2),           cx(0, -2),            cx(0, 1),            cx(0, -1)};
        v[7] = '{cx(20000, -30000),cx(0, 16384),        cx(16384, 0),         cx(20000, -21808),  cx(20000, -32768),    cx(10000, -10904),   cx(10000, -19096)};

        drive(cx(0, 0), cx(0, 0), cx(0, 0));
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_a", bus.A_out, cx(0, 0));
        chk("reset_b", bus.B_out, cx(0, 0));
        rst = 1'b0;

        // Each vector held for exactly three edges.
        for (int k = 0; k < NV; k++) begin
            drive(v[k].a, v[k].b, v[k].w);
            repeat (3) @(negedge clk);
            chk($sformatf("held%0d_a", k), bus.A_out, exp_a(k));
            chk($sformatf("held%0d_b", k), bus.B_out, exp_b(k));
        end

        // Back-to-back vectors; result j is due two loop steps after it is driven.
        for (int j = 0; j < NV + 2; j++) begin
            if (j < NV) drive(v[j].a, v[j].b, v[j].w);
            else        drive(cx(0, 0), cx(0, 0), cx(0, 0));
            @(negedge clk);
            if (j == 1) begin
                chk("lat_early_a", bus.A_out, exp_a(NV - 1));
                chk("lat_early_b", bus.B_out, exp_b(NV - 1));
            end
            if (j >= 2) begin
                chk($sformatf("stream%0d_a", j - 2), bus.A_out, exp_a(j - 2));
                chk($sformatf("stream%0d_b", j - 2), bus.B_out, exp_b(j - 2));
            end
        end

        // Reset with two butterflies in flight, then v[5] held through and after it.
        drive(v[0].a, v[0].b, v[0].w);
        @(negedge clk);
        drive(v[1].a, v[1].b, v[1].w);
        @(negedge clk);
        drive(v[5].a, v[5].b, v[5].w);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_a", bus.A_out, cx(0, 0));
        chk("rst_mid_b", bus.B_out, cx(0, 0));
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            if (e < 3) begin
                chk($sformatf("rst_flush%0d_a", e), bus.A_out, cx(0, 0));
                chk($sformatf("rst_flush%0d_b", e), bus.B_out, cx(0, 0));
            end else begin
                chk("rst_fresh_a", bus.A_out, exp_a(5));
                chk("rst_fresh_b", bus.B_out, exp_b(5));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
